i2c_reg_bank: RTL and testbench

Parametrised slave-side register bank for the I2C datapath. Accepts framed bytes (start / ack / data / nack / stop) addressed to this device and stores each payload in the lowest free slot of a DEPTH-entry bank. Provides indexed reads, per-slot release, occupancy count, full/empty flags, per-frame ack/nack response and a sticky overflow flag. Sits between the frame receiver and the controller logic that consumes received bytes.

---
 rtl/i2c_reg_bank.sv | 145 ++++++++++++++
 tb/tb_i2c_reg_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: slave-side storage for framed I2C bytes addressed to this device.
// Incoming payloads fill the lowest free slot. The controller reads slots by index
// and releases them explicitly. The block reports occupancy, ack/nack pulses and a
// sticky overflow flag.
module i2c_reg_bank #(
  parameter int                 DATA_W   = 8,
  parameter int                 DEPTH    = 6,
  parameter int                 ADDR_W   = 4,
  parameter logic [ADDR_W-1:0]  DEV_ADDR = 4'b0001,
  parameter int                 IDX_W    = $clog2(DEPTH),
  parameter int                 CNT_W    = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_valid,
  input  logic [DATA_W+3:0]     frame,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic                  rd_clr,
  input  logic                  clr_ovf,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  ack,
  output logic                  nack,
  output logic [DEPTH-1:0]      slot_valid,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             slot_valid_q, slot_valid_d;
  logic [DATA_W-1:0]            rd_data_q, rd_data_d;
  logic                         rd_valid_q, rd_valid_d;
  logic                         ack_q, ack_d;
  logic                         nack_q, nack_d;
  logic                         ovf_q, ovf_d;

  logic                         accept;
  logic                         found;
  logic [IDX_W-1:0]             wr_idx;
  logic                         rd_in_range;
  logic [IDX_W-1:0]             rd_sel;
  logic [CNT_W-1:0]             count_c;

  // Only the start bit is qualified. The ack, nack and stop bits are carried through unchecked.
  logic unused_frame_bits;
  assign unused_frame_bits = ^{frame[1], frame[DATA_W+3:DATA_W+2]};

  // Accept qualification, free-slot search over the pre-edge occupancy, and the read index guard.
  always_comb begin
    accept      = frame_valid && frame[0] && (addr == DEV_ADDR);
    found       = 1'b0;
    wr_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && !slot_valid_q[i]) begin
        found  = 1'b1;
        wr_idx = IDX_W'(i);
      end
    end
    rd_in_range = (32'(rd_idx) < DEPTH);
    // Clamp the index so that an out-of-range index never addresses past the array.
    rd_sel      = rd_in_range ? rd_idx : '0;
  end

  // Next-state logic for storage, occupancy, the read port, the response pulses and overflow.
  always_comb begin
    mem_d        = mem_q;
    slot_valid_d = slot_valid_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    ack_d        = 1'b0;
    nack_d       = 1'b0;
    ovf_d        = ovf_q;

    // A read samples the pre-edge contents, so a read and release in the same cycle returns the old data.
    if (rd_en) begin
      if (rd_in_range && slot_valid_q[rd_sel]) begin
        rd_data_d  = mem_q[rd_sel];
        rd_valid_d = 1'b1;
      end else begin
        rd_data_d  = '0;
      end
    end

    if (rd_clr && rd_in_range)
      slot_valid_d[rd_sel] = 1'b0;

    // wr_idx was free before the edge, so the write can never target the slot being released.
    if (accept) begin
      if (found) begin
        mem_d[wr_idx]        = frame[DATA_W+1:2];
        slot_valid_d[wr_idx] = 1'b1;
        ack_d                = 1'b1;
      end else begin
        nack_d = 1'b1;
      end
    end

    // A drop in the same cycle as the clear takes priority over the clear.
    if (clr_ovf) ovf_d = 1'b0;
    if (nack_d)  ovf_d = 1'b1;
  end

  // Register all of the state. Reset clears it at once, including any pending pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q        <= '0;
      slot_valid_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      ack_q        <= 1'b0;
      nack_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      slot_valid_q <= slot_valid_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      ack_q        <= ack_d;
      nack_q       <= nack_d;
      ovf_q        <= ovf_d;
    end
  end

  // The occupancy count is derived from slot_valid, so it cannot drift or wrap.
  always_comb begin
    count_c = '0;
    for (int i = 0; i < DEPTH; i++)
      count_c = count_c + CNT_W'(slot_valid_q[i]);
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign ack        = ack_q;
  assign nack       = nack_q;
  assign slot_valid = slot_valid_q;
  assign count      = count_c;
  assign full       = (32'(count_c) == DEPTH);
  assign empty      = (count_c == '0);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed, table-driven bench for i2c_reg_bank with the default parameters.
module tb_i2c_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_valid;
  logic [11:0] frame;
  logic [3:0]  addr;
  logic        rd_en;
  logic [2:0]  rd_idx;
  logic        rd_clr;
  logic        clr_ovf;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        ack;
  logic        nack;
  logic [5:0]  slot_valid;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  i2c_reg_bank dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame(frame), .addr(addr),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_clr(rd_clr), .clr_ovf(clr_ovf),
    .rd_data(rd_data), .rd_valid(rd_valid), .ack(ack), .nack(nack),
    .slot_valid(slot_valid), .count(count), .full(full), .empty(empty), .overflow(overflow)
  );

  typedef struct {
    string       name;
    logic        fv;
    logic [11:0] fr;
    logic [3:0]  ad;
    logic        re;
    logic [2:0]  ri;
    logic        rc;
    logic        co;
    logic        e_ack;
    logic        e_nack;
    logic [5:0]  e_sv;
    logic [2:0]  e_cnt;
    logic        e_ovf;
    logic        e_rdchk;
    logic [7:0]  e_rd;
    logic        e_rv;
  } vec_t;

  vec_t tbl[$];

  // Addressed frame with a start bit. The stop bit is set as well, to show that it is ignored.
  function automatic logic [11:0] fr(input logic [7:0] d);
    return {2'b10, d, 2'b01};
  endfunction

  function automatic vec_t mk(input string n, input logic fv, input logic [11:0] f, input logic [3:0] a,
                              input logic re, input logic [2:0] ri, input logic rc, input logic co,
                              input logic eack, input logic enack, input logic [5:0] esv,
                              input logic [2:0] ecnt, input logic eovf, input logic erdchk,
                              input logic [7:0] erd, input logic erv);
    vec_t v;
    v.name = n; v.fv = fv; v.fr = f; v.ad = a; v.re = re; v.ri = ri; v.rc = rc; v.co = co;
    v.e_ack = eack; v.e_nack = enack; v.e_sv = esv; v.e_cnt = ecnt; v.e_ovf = eovf;
    v.e_rdchk = erdchk; v.e_rd = erd; v.e_rv = erv;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    frame_valid = 0; frame = '0; addr = '0; rd_en = 0; rd_idx = '0; rd_clr = 0; clr_ovf = 0;
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, " ack"}, 32'(ack), 0);
    check({nm, " nack"}, 32'(nack), 0);
    check({nm, " slot_valid"}, 32'(slot_valid), 0);
    check({nm, " count"}, 32'(count), 0);
    check({nm, " empty"}, 32'(empty), 1);
    check({nm, " full"}, 32'(full), 0);
    check({nm, " overflow"}, 32'(overflow), 0);
    check({nm, " rd_data"}, 32'(rd_data), 0);
    check({nm, " rd_valid"}, 32'(rd_valid), 0);
  endtask

  task automatic apply(input vec_t t);
    @(negedge clk);
    frame_valid = t.fv; frame = t.fr; addr = t.ad; rd_en = t.re; rd_idx = t.ri;
    rd_clr = t.rc; clr_ovf = t.co;
    @(posedge clk);
    #1;
    check({t.name, " ack"}, 32'(ack), 32'(t.e_ack));
    check({t.name, " nack"}, 32'(nack), 32'(t.e_nack));
    check({t.name, " slot_valid"}, 32'(slot_valid), 32'(t.e_sv));
    check({t.name, " count"}, 32'(count), 32'(t.e_cnt));
    check({t.name, " full"}, 32'(full), 32'(t.e_cnt == 3'd6));
    check({t.name, " empty"}, 32'(empty), 32'(t.e_cnt == 3'd0));
    check({t.name, " overflow"}, 32'(overflow), 32'(t.e_ovf));
    check({t.name, " rd_valid"}, 32'(rd_valid), 32'(t.e_rv));
    if (t.e_rdchk) check({t.name, " rd_data"}, 32'(rd_data), 32'(t.e_rd));
  endtask

  initial begin
    //             name        fv  frame             addr  re ri rc co  ack nack sv         cnt ovf chk rd     rv
    tbl.push_back(mk("wrong_addr", 1, 12'b110011001111, 4'd2, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk("no_start",   1, 12'b110011001110, 4'd1, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk("fv_low",     0, 12'b110011001111, 4'd1, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk("first_wr",   1, 12'b110011001111, 4'd1, 0, 0, 0, 0, 1, 0, 6'b000001, 1, 0, 1, 8'h00, 0));
    tbl.push_back(mk("read0",      0, 12'h000,          4'd0, 1, 0, 0, 0, 0, 0, 6'b000001, 1, 0, 1, 8'h33, 1));
    tbl.push_back(mk("rd_hold",    0, 12'h000,          4'd0, 0, 0, 0, 0, 0, 0, 6'b000001, 1, 0, 1, 8'h33, 0));
    tbl.push_back(mk("clr0",       0, 12'h000,          4'd0, 0, 0, 1, 0, 0, 0, 6'b000000, 0, 0, 1, 8'h33, 0));
    tbl.push_back(mk("rd_empty",   0, 12'h000,          4'd0, 1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1, 8'h00, 0));
    tbl.push_back(mk("burst1",     1, fr(8'h01),        4'd1, 0, 0, 0, 0, 1, 0, 6'b000001, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk("burst2",     1, fr(8'h02),        4'd1, 0, 0, 0, 0, 1, 0, 6'b000011, 2, 0, 0, 8'h00, 0));
    tbl.push_back(mk("burst3",     1, fr(8'h03),        4'd1, 0, 0, 0, 0, 1, 0, 6'b000111, 3, 0, 0, 8'h00, 0));
    tbl.push_back(mk("burst4",     1, fr(8'h04),        4'd1, 0, 0, 0, 0, 1, 0, 6'b001111, 4, 0, 0, 8'h00, 0));
    tbl.push_back(mk("burst5",     1, fr(8'h05),        4'd1, 0, 0, 0, 0, 1, 0, 6'b011111, 5, 0, 0, 8'h00, 0));
    tbl.push_back(mk("burst6",     1, fr(8'h06),        4'd1, 0, 0, 0, 0, 1, 0, 6'b111111, 6, 0, 0, 8'h00, 0));
    tbl.push_back(mk("burst7_drop",1, fr(8'h07),        4'd1, 0, 0, 0, 0, 0, 1, 6'b111111, 6, 1, 0, 8'h00, 0));
    tbl.push_back(mk("read3",      0, 12'h000,          4'd0, 1, 3, 0, 0, 0, 0, 6'b111111, 6, 1, 1, 8'h04, 1));
    tbl.push_back(mk("read5",      0, 12'h000,          4'd0, 1, 5, 0, 0, 0, 0, 6'b111111, 6, 1, 1, 8'h06, 1));
    tbl.push_back(mk("read_oor",   0, 12'h000,          4'd0, 1, 6, 0, 0, 0, 0, 6'b111111, 6, 1, 1, 8'h00, 0));
    tbl.push_back(mk("clr_oor",    0, 12'h000,          4'd0, 0, 7, 1, 0, 0, 0, 6'b111111, 6, 1, 1, 8'h00, 0));
    tbl.push_back(mk("clr_ovf",    0, 12'h000,          4'd0, 0, 0, 0, 1, 0, 0, 6'b111111, 6, 0, 0, 8'h00, 0));
    tbl.push_back(mk("clr_vs_drop",1, fr(8'h77),        4'd1, 0, 0, 0, 1, 0, 1, 6'b111111, 6, 1, 0, 8'h00, 0));
    tbl.push_back(mk("clr_ovf2",   0, 12'h000,          4'd0, 0, 0, 0, 1, 0, 0, 6'b111111, 6, 0, 0, 8'h00, 0));
    tbl.push_back(mk("release2",   0, 12'h000,          4'd0, 0, 2, 1, 0, 0, 0, 6'b111011, 5, 0, 0, 8'h00, 0));
    tbl.push_back(mk("refill2",    1, fr(8'hA5),        4'd1, 0, 0, 0, 0, 1, 0, 6'b111111, 6, 0, 0, 8'h00, 0));
    tbl.push_back(mk("read2",      0, 12'h000,          4'd0, 1, 2, 0, 0, 0, 0, 6'b111111, 6, 0, 1, 8'hA5, 1));
    tbl.push_back(mk("full_clr_wr",1, fr(8'hBB),        4'd1, 0, 4, 1, 0, 0, 1, 6'b101111, 5, 1, 0, 8'h00, 0));
    tbl.push_back(mk("refill4",    1, fr(8'hCC),        4'd1, 0, 0, 0, 1, 1, 0, 6'b111111, 6, 0, 0, 8'h00, 0));
    tbl.push_back(mk("rd_and_clr0",0, 12'h000,          4'd0, 1, 0, 1, 0, 0, 0, 6'b111110, 5, 0, 1, 8'h01, 1));
    tbl.push_back(mk("reread0",    0, 12'h000,          4'd0, 1, 0, 0, 0, 0, 0, 6'b111110, 5, 0, 1, 8'h00, 0));
    tbl.push_back(mk("clr_empty0", 0, 12'h000,          4'd0, 0, 0, 1, 0, 0, 0, 6'b111110, 5, 0, 1, 8'h00, 0));
    tbl.push_back(mk("wr_clr_net", 1, fr(8'h5A),        4'd1, 0, 1, 1, 0, 1, 0, 6'b111101, 5, 0, 0, 8'h00, 0));
    tbl.push_back(mk("read0_5a",   0, 12'h000,          4'd0, 1, 0, 0, 0, 0, 0, 6'b111101, 5, 0, 1, 8'h5A, 1));
    tbl.push_back(mk("rd_wr_same", 1, fr(8'h66),        4'd1, 1, 1, 0, 0, 1, 0, 6'b111111, 6, 0, 1, 8'h00, 0));
    tbl.push_back(mk("read1_66",   0, 12'h000,          4'd0, 1, 1, 0, 0, 0, 0, 6'b111111, 6, 0, 1, 8'h66, 1));

    idle();
    rst = 1'b1;
    #1;
    check_reset_vals("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // The bank is full. Drop two frames with a read in flight, then reset in the middle of a cycle.
    @(negedge clk);
    frame_valid = 1; frame = fr(8'h10); addr = 4'd1; rd_en = 1; rd_idx = 3'd1;
    @(posedge clk); #1;
    check("mid nack", 32'(nack), 1);
    check("mid rd_valid", 32'(rd_valid), 1);
    @(negedge clk);
    frame = fr(8'h11); rd_en = 0;
    @(posedge clk); #1;
    check("mid overflow", 32'(overflow), 1);
    check("mid nack2", 32'(nack), 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk); #1;
    check_reset_vals("rst_held");
    @(negedge clk);
    rst = 1'b0;
    frame = fr(8'h42);
    @(posedge clk); #1;
    check("post_rst ack", 32'(ack), 1);
    check("post_rst slot_valid", 32'(slot_valid), 32'h01);
    @(negedge clk);
    idle();
    rd_en = 1; rd_idx = 3'd0;
    @(posedge clk); #1;
    check("post_rst rd_data", 32'(rd_data), 32'h42);
    check("post_rst rd_valid", 32'(rd_valid), 1);
    @(negedge clk);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
